// File: rtl/stream_mux_arb.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_arb
// Purpose  : Merges CHANNELS valid/ready source streams of WIDTH bits onto a
//            single registered valid/ready output stream. The channel choice
//            is made by one of three arbitration modes, fixed at elaboration:
//              MODE 0 : fixed priority (lowest index wins)
//              MODE 1 : round-robin (search starts after the last grant)
//              MODE 2 : external select via sel (legacy select-mux behaviour)
//            The block adds one cycle of registered latency and passes
//            backpressure straight through to the sources.
//
// Ports    : clk        rising-edge clock
//            rst_n      asynchronous active-low reset
//            in_data    flattened channel data, channel i at [i*WIDTH +: WIDTH]
//            in_valid   per-channel valid
//            in_ready   per-channel ready, at most one bit high
//            sel        channel select (only used when MODE=2)
//            out_data   registered output data
//            out_chan   index of the channel that supplied out_data
//            out_valid  output valid
//            out_ready  downstream ready
//
// Revision : 1.0 - initial release
// ============================================================================
module stream_mux_arb #(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 4,
    parameter  int MODE     = 1,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // ------------------------------------------------------------------------
    // Channel data unpacked into an array so the selected word can be
    // indexed directly by the grant index.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_chan_data [CHANNELS];

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
        assign w_chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end

    // ------------------------------------------------------------------------
    // Output register state
    // ------------------------------------------------------------------------
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_chan;

    // The output register can take a new word when it is empty or when the
    // word it holds is leaving this cycle (pop and accept on the same edge).
    logic w_load;
    assign w_load = !r_out_valid || out_ready;

    // Grant: one winner (w_grant_vld with w_grant_idx) or none.
    logic             w_grant_vld;
    logic [SEL_W-1:0] w_grant_idx;

    // ------------------------------------------------------------------------
    // Arbitration, one implementation per mode
    // ------------------------------------------------------------------------
    if (MODE == 1) begin : g_rr
        // Index of the most recently granted channel. Reset to the highest
        // index so channel 0 is first in line after reset.
        logic [SEL_W-1:0] r_last;

        // sel has no meaning in this mode.
        logic w_unused_sel;
        assign w_unused_sel = ^sel;

        // Each requester gets a rank equal to its distance from the slot
        // after r_last (0 = highest priority); the smallest rank wins.
        always_comb begin
            int v_best;
            int v_rank;
            w_grant_vld = 1'b0;
            w_grant_idx = '0;
            v_best      = CHANNELS;
            v_rank      = 0;
            for (int i = 0; i < CHANNELS; i++) begin
                if (in_valid[i]) begin
                    v_rank = (i + CHANNELS - 1 - int'(r_last)) % CHANNELS;
                    if (v_rank < v_best) begin
                        v_best      = v_rank;
                        w_grant_vld = 1'b1;
                        w_grant_idx = SEL_W'(i);
                    end
                end
            end
        end

        // The pointer only moves on an accepted grant; idle or stalled
        // cycles leave the rotation where it was.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_last <= SEL_W'(CHANNELS - 1);
            end else if (w_load && w_grant_vld) begin
                r_last <= w_grant_idx;
            end
        end
    end else if (MODE == 2) begin : g_sel
        // Legacy select behaviour: the selected channel is granted only if
        // it is in range and actually valid. Other valid channels are never
        // considered, even when the selected one is idle.
        always_comb begin
            w_grant_vld = 1'b0;
            w_grant_idx = '0;
            if (int'(sel) < CHANNELS) begin
                w_grant_vld = in_valid[sel];
                w_grant_idx = sel;
            end
        end
    end else begin : g_fixed
        // sel has no meaning in this mode.
        logic w_unused_sel;
        assign w_unused_sel = ^sel;

        // Scan from the top down so the last hit, the lowest index, wins.
        always_comb begin
            w_grant_vld = 1'b0;
            w_grant_idx = '0;
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = SEL_W'(i);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Ready back to the sources. Combinational from out_ready (no skid
    // buffer), and held low throughout reset so no source believes a word
    // was taken while the output register is being cleared.
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready = '0;
        if (rst_n && w_load && w_grant_vld) begin
            in_ready[w_grant_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Output register. With no grant on a load cycle only the valid flag
    // drops; data and channel keep their last values.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
        end else if (w_load) begin
            if (w_grant_vld) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_chan_data[w_grant_idx];
                r_out_chan  <= w_grant_idx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

endmodule
`default_nettype wire

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
- Parametrised successor to the datapath 2:1 select muxes. Merges CHANNELS valid/ready source streams of WIDTH bits onto one registered output stream.
- Channel choice is made by one of three modes, fixed at elaboration:
  - fixed priority
  - round-robin
  - external select (the legacy sel-driven behaviour)
- Sits between multiple producers (e.g. ALU result, load data, immediate path) and a single register-file write or bus port.
- Provides one cycle of registered latency and backpressure.

Parameters:
- WIDTH, 16, data width of every channel and of the output.
- CHANNELS, 4, number of input channels (2..16).
- MODE, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin, 2 = external select via sel.
- SEL_W, localparam = max(1, clog2(CHANNELS)), width of the channel index.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  CHANNELS*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready; at most one bit high
- sel  input  SEL_W  channel select, used only when MODE=2
- out_data  output  WIDTH  registered output data
- out_chan  output  SEL_W  index of the channel that supplied out_data
- out_valid  output  1  output valid
- out_ready  input  1  downstream ready

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-to-clk release):
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer last=CHANNELS-1, so channel 0 has first priority.
  - in_ready forced to all-zero while rst_n is low.
- load = !out_valid || out_ready. The output register accepts a new word only when load=1.
- Grant g (combinational, one-hot or none), evaluated every cycle:
  - MODE 0: lowest index i with in_valid[i]=1.
  - MODE 1: first i with in_valid[i]=1, searching last+1, last+2, ... with wrap modulo CHANNELS.
  - MODE 2: g=sel if sel<CHANNELS and in_valid[sel]=1; otherwise no grant. sel>=CHANNELS never grants.
- in_ready[i] = load && (g==i). in_ready has a combinational path from out_ready (no skid buffer).
- Handshake per input: a transfer occurs on a clk edge where in_valid[i] && in_ready[i].
- Rising edge with load=1 and a grant:
  - out_data <= channel g data, out_chan <= g, out_valid <= 1.
  - MODE 1 only: last <= g.
- Rising edge with load=1 and no grant: out_valid <= 0; out_data and out_chan hold their values.
- Rising edge with load=0: all registers hold, the output word is stable, and every in_ready is 0.
- Latency: an accepted input appears on out_data on the next edge.
  - Sustained throughput is 1 word/cycle when out_ready=1.
  - Downstream transfer occurs when out_valid && out_ready.
- Fairness:
  - MODE 1: no requester waits more than CHANNELS-1 grants while continuously valid.
  - MODE 0: may starve high indices (intended).
- The pointer changes only on an actual grant. Idle cycles leave it unchanged.
- Simultaneous downstream pop and new accept in the same cycle is legal; there is no bubble.
- Reset mid-transfer discards the held word; there is no partial output.
- Sources must hold in_data/in_valid stable until their handshake; the block does not check this.
- CHANNELS=2, MODE=2, WIDTH=4 reproduces the legacy 2:1 4-bit select, with one added cycle of registration.

Test Plan:
- Reset with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_chan=0. First edge after release grants ch0; out_chan=0 next cycle.
- MODE 1, all four channels valid continuously, out_ready=1, data ch_i=16'hA000+i -> out_chan sequence 0,1,2,3,0,1, one word per cycle, matching data.
- MODE 0, in_valid=4'b1010, out_ready=1 -> always grants ch1, out_data=16'hA001 every cycle, in_ready=4'b0010.
- Backpressure: out_valid=1 and out_ready=0 for 3 cycles -> out_data/out_chan stable, in_ready=0. On release, the pop and the next accept happen on the same edge.
- MODE 2, sel=2 with in_valid[2]=1 -> out_chan=2. Then sel=2 with in_valid[2]=0 and others valid -> no grant, out_valid drops to 0 after the pending word pops. Out-of-range sel (CHANNELS=3, sel=3) -> no grant.
- MODE 1 pointer hold: grant ch2, then 2 idle cycles, then in_valid=4'b1111 -> next grant is ch3, not ch0.
